ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Scan-code sequencer between the PS/2 byte receiver and the game logic. It consumes raw bytes, tracks make (press), break (release, `F0` prefix) and extended (`E0` prefix) sequences, and keeps a held-state bitmap for the eight game keys. Every held-state change is queued as an event in a small first-word-fall-through (FWFT) FIFO. Paddle motion, menus and pause logic read `key_held`; edge-driven consumers pop events.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 65536 — cycles allowed in a prefix state before the sequence is abandoned (1.31 ms at 50 MHz).
- `FIFO_DEPTH`, 4 — event FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1 — system clock, 50 MHz.
- `rst`  in  1 — asynchronous, active-low reset.
- `code`  in  8 — byte from the PS/2 receiver.
- `valid`  in  1 — receiver strobe; a level that may stay high for many cycles.
- `key_held`  out  8 — bit i = key i currently pressed.
- `evt_valid`  out  1 — FIFO not empty.
- `evt_data`  out  4 — FIFO head: `{make, idx[2:0]}`.
- `evt_ready`  in  1 — consumer pops the head when `evt_valid` && `evt_ready`.
- `overflow`  out  1 — sticky; set when an event is dropped; cleared only by reset.

## Operation
- Key map (idx: code):
  - 0 W `1D`, 1 S `1B`, 2 O `44`, 3 L `4B`.
  - 4 Space `29`, 5 Enter `5A`.
  - 6 Up `E0 75`, 7 Down `E0 72`.
- Idx 6 and 7 match only inside an extended sequence. Bare `75`/`72` (keypad) are unmapped. Extended forms of idx 0–5 codes are unmapped.
- Byte acceptance: rising edge of `valid` (`valid`=1, registered `valid_d`=0). Exactly one accept per high period.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
- IDLE:
  - `F0` → BRK.
  - `E0` → EXT.
  - mapped non-extended code → make; stay in IDLE.
  - anything else → ignored.
- EXT:
  - `F0` → EXT_BRK.
  - mapped extended code → make, → IDLE.
  - anything else (including `E0`) → IDLE, no action.
- BRK / EXT_BRK:
  - next byte ends the sequence → IDLE.
  - if that byte is mapped under the state's extended-ness → break.
  - prefix bytes `E0`/`F0` here → IDLE, no action.
- Make on a key already held (typematic repeat): no change, no event.
- Break on a key not held: no change, no event.
- Events are generated only on `key_held` transitions: make → `{1,idx}`, break → `{0,idx}`.
- Timeout counter:
  - clears in IDLE and on every accept;
  - otherwise increments each cycle;
  - at `TIMEOUT_CYCLES-1` the FSM forces IDLE with no action.
  - A byte accepted in that same cycle takes priority over the timeout.
- FIFO rules:
  - push when an event is generated;
  - full and no pop that cycle → event dropped, `overflow` set; `key_held` still updates;
  - full with pop in the same cycle → both push and pop occur;
  - empty with push → `evt_valid` rises next cycle (no bypass).

## Timing
- Reset values:
  - `key_held`=0, `evt_valid`=0, `evt_data`=0, `overflow`=0;
  - FSM in IDLE; counter=0; `valid_d`=0.
- If `valid` is already high at reset release, no byte is accepted until `valid` falls and rises again.
- Latency, accept at edge N:
  - `key_held` updates at N+1;
  - event visible on `evt_valid`/`evt_data` at N+1.
- `evt_data` holds stable while `evt_valid` && !`evt_ready`.
- Pointer widths are `$clog2(FIFO_DEPTH)`; the count is one bit wider. Pointers wrap modulo `FIFO_DEPTH`.
- Counter width is `$clog2(TIMEOUT_CYCLES)`.
- Reset mid-sequence (e.g. after `F0`): all state clears; the following byte is interpreted from IDLE.

## Structure
- Package `ps2_pkg` holds:
  - scan-code constants `BREAK_CODE`, `EXT_CODE` and the eight key codes;
  - the key-index enum;
  - the `key_event_t` typedef `{make, idx}`;
  - the FSM state enum.
- Sub-module `key_event_fifo`: FWFT synchronous FIFO, parameterised depth and width, with push/pop, full/empty and same-cycle push+pop when full.
- Byte-edge detect, FSM, timeout counter and held-bitmap logic live in the top module.

## Test plan
- Bytes `1D`, `F0 1D` → `key_held[0]` rises then falls; events `{1,0}` then `{0,0}`; `overflow`=0.
- `E0 75`, then `E0 F0 75` → `key_held[6]` toggles 1→0; bare `75` → no change, no event.
- `1B` sent 5× (repeat) then `F0 1B` → exactly 2 events, `{1,1}` and `{0,1}`.
- `F0`, idle `TIMEOUT_CYCLES`+10 cycles, then `44` → FSM back in IDLE; `44` treated as make; `key_held[2]`=1.
- `evt_ready`=0, press/release W, S, O → 4 events stored, 5th and 6th dropped, `overflow`=1; with `FIFO_DEPTH`=4, the `key_held` bits (0, 1, 2) still track the keys.
- Send `F0`, assert `rst` low, release, send `29` → `key_held[4]`=1; event `{1,4}`.
- `valid` held high 1000 cycles with `1D` → a single accept.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key indices, event word and decoder states for the PS/2 key path.
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_O     = 8'h44;
    localparam logic [7:0] CODE_L     = 8'h4B;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;

    typedef enum logic [2:0] {
        KEY_W     = 3'd0,
        KEY_S     = 3'd1,
        KEY_O     = 3'd2,
        KEY_L     = 3'd3,
        KEY_SPACE = 3'd4,
        KEY_ENTER = 3'd5,
        KEY_UP    = 3'd6,
        KEY_DOWN  = 3'd7
    } key_idx_e;

    typedef struct packed {
        logic     make;
        key_idx_e idx;
    } key_event_t;

    typedef struct packed {
        logic     hit;
        key_idx_e idx;
    } key_lookup_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Up/Down exist only as E0-prefixed codes; the plain keys only without the prefix.
    function automatic key_lookup_t lookup_key(input logic [7:0] c, input logic ext);
        key_lookup_t r;
        r.hit = 1'b0;
        r.idx = KEY_W;
        if (!ext) begin
            case (c)
                CODE_W:     begin r.hit = 1'b1; r.idx = KEY_W;     end
                CODE_S:     begin r.hit = 1'b1; r.idx = KEY_S;     end
                CODE_O:     begin r.hit = 1'b1; r.idx = KEY_O;     end
                CODE_L:     begin r.hit = 1'b1; r.idx = KEY_L;     end
                CODE_SPACE: begin r.hit = 1'b1; r.idx = KEY_SPACE; end
                CODE_ENTER: begin r.hit = 1'b1; r.idx = KEY_ENTER; end
                default:    r.hit = 1'b0;
            endcase
        end else begin
            case (c)
                CODE_UP:    begin r.hit = 1'b1; r.idx = KEY_UP;    end
                CODE_DOWN:  begin r.hit = 1'b1; r.idx = KEY_DOWN;  end
                default:    r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO for key events; a push into a full FIFO succeeds only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    // Head is forced to zero when empty so the output is defined straight out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code sequencer: tracks make/break/extended prefixes, keeps the held bitmap
// for the eight game keys and queues every held-state change as an event.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | no prefix pending; makes are decoded directly
//   ST_EXT     | E0 seen; next byte is an extended make or F0
//   ST_BRK     | F0 seen; next byte is a plain key release
//   ST_EXT_BRK | E0 F0 seen; next byte is an extended key release
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       valid,
    output logic [7:0] key_held,
    output logic       evt_valid,
    output logic [3:0] evt_data,
    input  logic       evt_ready,
    output logic       overflow
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dec_state_e       state;
    dec_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic             valid_d;
    logic             seen_low;
    logic             accept;
    logic             timed_out;
    key_lookup_t      lk;
    logic             do_make;
    logic             do_break;
    logic             evt_push;
    key_event_t       evt_word;
    logic [7:0]       held_next;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;

    // seen_low blocks an accept when valid is already high coming out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_d  <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            valid_d  <= valid;
            seen_low <= seen_low | ~valid;
        end
    end

    assign accept    = valid && !valid_d && seen_low;
    assign timed_out = (state != ST_IDLE) && (cnt == CNT_LAST);
    assign lk        = lookup_key(code, (state == ST_EXT) || (state == ST_EXT_BRK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (code == BREAK_CODE)    state_next = ST_BRK;
                    else if (code == EXT_CODE) state_next = ST_EXT;
                    else                       do_make    = lk.hit;
                end
                ST_EXT: begin
                    if (code == BREAK_CODE) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                        do_make    = lk.hit;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    do_break   = lk.hit;
                end
            endcase
        end else if (timed_out) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept || timed_out || state == ST_IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Only real transitions of the bitmap produce events; repeats and stray breaks are silent.
    always_comb begin
        held_next     = key_held;
        evt_push      = 1'b0;
        evt_word.make = do_make;
        evt_word.idx  = lk.idx;
        if (do_make && !key_held[lk.idx]) begin
            held_next[lk.idx] = 1'b1;
            evt_push          = 1'b1;
        end
        if (do_break && key_held[lk.idx]) begin
            held_next[lk.idx] = 1'b0;
            evt_push          = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_held <= '0;
            overflow <= 1'b0;
        end else begin
            key_held <= held_next;
            overflow <= overflow | fifo_drop;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_event_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data (evt_word),
        .pop       (evt_ready),
        .pop_data  (evt_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: queue-based reference model checked every cycle, plus
// directed sequences with literal expectations and a randomized byte stream.
module tb_ps2_key_decoder;

    localparam int T = 64;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] code = 8'h00;
    logic       valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic [7:0] key_held;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       overflow;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .valid     (valid),
        .key_held  (key_held),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference key table: index i is pressed by code m_codes[i] with prefix flag m_isext[i].
    logic [7:0] m_codes [8] = '{8'h1D, 8'h1B, 8'h44, 8'h4B, 8'h29, 8'h5A, 8'h75, 8'h72};
    bit         m_isext [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

    function automatic int m_lookup(input logic [7:0] c, input bit ext);
        for (int i = 0; i < 8; i++)
            if (m_codes[i] == c && m_isext[i] == ext) return i;
        return -1;
    endfunction

    bit         m_prev_valid, m_low_seen, m_brk, m_ext, m_ovf;
    int         m_age;
    logic [7:0] m_held;
    logic [3:0] m_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev_valid = 0; m_low_seen = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
            m_age = 0; m_held = 8'h00; m_q.delete();
        end else begin
            bit acc;
            int idx;
            int ev;
            bit mk;
            acc = valid && !m_prev_valid && m_low_seen;
            m_low_seen = m_low_seen || !valid;
            m_prev_valid = valid;
            ev = -1;
            idx = -1;
            mk = 0;
            if (acc) begin
                m_age = 0;
                if (m_brk) begin
                    idx = m_lookup(code, m_ext);
                    mk = 0;
                    m_brk = 0; m_ext = 0;
                end else if (m_ext) begin
                    if (code == 8'hF0) m_brk = 1;
                    else begin idx = m_lookup(code, 1); mk = 1; m_ext = 0; end
                end else begin
                    if (code == 8'hF0)      m_brk = 1;
                    else if (code == 8'hE0) m_ext = 1;
                    else begin idx = m_lookup(code, 0); mk = 1; end
                end
                if (idx >= 0 && m_held[idx] != mk) begin
                    m_held[idx] = mk;
                    ev = {mk, idx[2:0]};
                end
            end else if (m_brk || m_ext) begin
                if (m_age == T - 1) begin
                    m_brk = 0; m_ext = 0; m_age = 0;
                end else begin
                    m_age++;
                end
            end
            if (evt_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (ev >= 0) begin
                if (m_q.size() < D) m_q.push_back(ev[3:0]);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("key_held", {24'h0, key_held}, {24'h0, m_held});
            chk("evt_valid", {31'h0, evt_valid}, {31'h0, m_q.size() != 0});
            chk("evt_data", {28'h0, evt_data}, {28'h0, (m_q.size() != 0) ? m_q[0] : 4'h0});
            chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        end
    end

    logic [3:0] ev_log[$];
    always @(negedge clk) begin
        if (rst && evt_valid && evt_ready) ev_log.push_back(evt_data);
    end

    task automatic chk_log(input string name, input int n, input logic [15:0] exp);
        logic [3:0] e;
        chk({name, ".count"}, ev_log.size(), n);
        for (int i = 0; i < n && i < ev_log.size(); i++) begin
            e = exp[15 - 4*i -: 4];
            chk(name, {28'h0, ev_log[i]}, {28'h0, e});
        end
        ev_log.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] c, input int hold, input int gap);
        code = c;
        valid = 1'b1;
        tick(hold);
        valid = 1'b0;
        tick(gap);
    endtask

    task automatic send(input logic [7:0] c);
        send_byte(c, 2, 3);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        rst = 1'b0;
        tick(3);
        chk("reset.key_held", {24'h0, key_held}, 32'h0);
        chk("reset.evt_valid", {31'h0, evt_valid}, 32'h0);
        chk("reset.evt_data", {28'h0, evt_data}, 32'h0);
        chk("reset.overflow", {31'h0, overflow}, 32'h0);
        rst = 1'b1;
        tick(2);
        evt_ready = 1'b1;

        send(8'h1D);
        chk("w.press", {31'h0, key_held[0]}, 32'h1);
        send(8'hF0); send(8'h1D);
        chk("w.release", {31'h0, key_held[0]}, 32'h0);
        chk_log("w.events", 2, 16'h8000);
        chk("w.overflow", {31'h0, overflow}, 32'h0);

        send(8'hE0); send(8'h75);
        chk("up.press", {31'h0, key_held[6]}, 32'h1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up.release", {31'h0, key_held[6]}, 32'h0);
        send(8'h75);
        chk("keypad.held", {24'h0, key_held}, 32'h0);
        chk_log("up.events", 2, 16'hE600);

        repeat (5) send(8'h1B);
        chk("s.repeat", {31'h0, key_held[1]}, 32'h1);
        send(8'hF0); send(8'h1B);
        chk_log("s.events", 2, 16'h9100);

        send(8'hF0);
        tick(T + 10);
        send(8'h44);
        chk("timeout.o", {31'h0, key_held[2]}, 32'h1);
        send(8'hF0); send(8'h44);
        chk_log("timeout.events", 2, 16'hA200);

        evt_ready = 1'b0;
        send(8'h1D); send(8'h1B); send(8'h44);
        chk("ovf.held3", {24'h0, key_held}, 32'h07);
        send(8'hF0); send(8'h1D);
        send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h44);
        chk("ovf.held0", {24'h0, key_held}, 32'h00);
        chk("ovf.flag", {31'h0, overflow}, 32'h1);
        chk("ovf.head", {28'h0, evt_data}, 32'h8);
        evt_ready = 1'b1;
        tick(8);
        chk_log("ovf.events", 4, 16'h89A0);
        chk("ovf.sticky", {31'h0, overflow}, 32'h1);

        send(8'hF0);
        do_reset();
        chk("rst.overflow", {31'h0, overflow}, 32'h0);
        send(8'h29);
        chk("rst.space", {24'h0, key_held}, 32'h10);
        chk_log("rst.events", 1, 16'hC000);

        code = 8'h1D;
        valid = 1'b1;
        do_reset();
        tick(5);
        chk("validhigh.noaccept", {24'h0, key_held}, 32'h00);
        valid = 1'b0;
        tick(2);
        send_byte(8'h1D, 1000, 3);
        chk("longvalid.held", {24'h0, key_held}, 32'h01);
        chk_log("longvalid.events", 1, 16'h8000);
        send(8'hF0); send(8'h1D);
        ev_log.delete();

        for (int n = 0; n < 700; n++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 9);
            case (r)
                4:       c = 8'hF0;
                5:       c = 8'hE0;
                6:       c = ($urandom_range(0, 1) != 0) ? 8'h75 : 8'h72;
                7:       c = 8'($urandom_range(0, 255));
                default: c = m_codes[$urandom_range(0, 7)];
            endcase
            evt_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0)
                send_byte(c, $urandom_range(1, 4), $urandom_range(T - 4, T + 2));
            else
                send_byte(c, $urandom_range(1, 4), $urandom_range(1, 3));
        end
        evt_ready = 1'b1;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
